// File: rtl/aes_pkg.sv
// Shared AES datapath definitions.
//   AES_BLOCK_W / AES_BYTE_W / AES_NBYTES : state geometry
//   state_t                               : control FSM encoding for the SubBytes stage
//   byte_msb(k)                           : MSB bit index of state byte k (byte 0 at [127:120])
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte k occupies [AES_BLOCK_W-1-AES_BYTE_W*k -: AES_BYTE_W].
    function automatic int byte_msb(input int k);
        return AES_BLOCK_W - 1 - AES_BYTE_W * k;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box / inverse S-box table lookup.
//   din  : byte to substitute
//   inv  : 0 = forward S-box, 1 = inverse S-box
//   dout : substituted byte
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] din,
    input  logic                  inv,
    output logic [AES_BYTE_W-1:0] dout
);

    localparam int TAB_W = 256 * AES_BYTE_W;

    // Entry i lives at [TAB_W-1-8*i -: 8]; rows hold entries 16r .. 16r+15.
    localparam logic [TAB_W-1:0] FWD_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [TAB_W-1:0] INV_TAB = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    always_comb begin
        if (inv) begin
            dout = INV_TAB[TAB_W - 1 - AES_BYTE_W * int'(din) -: AES_BYTE_W];
        end else begin
            dout = FWD_TAB[TAB_W - 1 - AES_BYTE_W * int'(din) -: AES_BYTE_W];
        end
    end

endmodule

// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes / InvSubBytes stage with valid/ready on both sides.
// BPC S-boxes are time-shared over the 16 state bytes; a block takes
// NSTEP = 16/BPC substitution cycles, walking from byte 0 (MSB) downward.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_data (byte 0 at [127:120]), in_inv
//   out_valid/out_ready : output handshake; out_data, out_inv held until taken
//   busy                : high whenever the FSM is not IDLE
module sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BPC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   out_inv,
    output logic                   busy
);

    localparam int NSTEP = AES_NBYTES / BPC;
    localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    generate
        if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : g_bad_bpc
            $error("sub_bytes_seq: BPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [AES_BLOCK_W-1:0] work_reg, work_next;
    logic                   inv_reg, inv_next;
    logic [AES_BYTE_W-1:0]  sb_in  [BPC];
    logic [AES_BYTE_W-1:0]  sb_out [BPC];
    logic                   accept;
    logic                   last_step;

    assign accept    = in_valid & in_ready;
    assign last_step = (cnt_reg == CNT_W'(NSTEP - 1));

    // S-box lane gi handles byte cnt*BPC+gi of the working register.
    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_lane
            assign sb_in[gi] = work_reg[byte_msb(int'(cnt_reg) * BPC + gi) -: AES_BYTE_W];

            aes_sbox u_sbox (
                .din  (sb_in[gi]),
                .inv  (inv_reg),
                .dout (sb_out[gi])
            );
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers; reset clears them so a discarded block never shows up on out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            work_reg <= '0;
            inv_reg  <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            work_reg <= work_next;
            inv_reg  <= inv_next;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        work_next  = work_reg;
        inv_next   = inv_reg;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    work_next  = in_data;
                    inv_next   = in_inv;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < BPC; i++) begin
                    work_next[byte_msb(int'(cnt_reg) * BPC + i) -: AES_BYTE_W] = sb_out[i];
                end
                if (last_step) begin
                    cnt_next   = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DONE: begin
                // in_ready follows out_ready here, so accept implies the result was taken.
                if (out_ready) begin
                    if (accept) begin
                        work_next  = in_data;
                        inv_next   = in_inv;
                        cnt_next   = '0;
                        state_next = RUN;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_reg != IDLE);
        unique case (state_reg)
            IDLE:    in_ready = 1'b1;
            RUN:     in_ready = 1'b0;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign out_data = work_reg;
    assign out_inv  = inv_reg;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Testbench for sub_bytes_seq: four instances with BPC = 4, 1, 2, 16 share clk/rst.
// Expected blocks come from an algorithmic S-box model (GF(2^8) inverse + affine map)
// pushed to a scoreboard at each input handshake and popped at each output handshake.
module tb_sub_bytes_seq;

    localparam int NDUT = 4;
    localparam int BPC_TAB [NDUT] = '{4, 1, 2, 16};

    typedef struct {
        logic         inv;
        logic [127:0] data;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid  [NDUT];
    logic         in_ready  [NDUT];
    logic [127:0] in_data   [NDUT];
    logic         in_inv    [NDUT];
    logic         out_valid [NDUT];
    logic         out_ready [NDUT];
    logic [127:0] out_data  [NDUT];
    logic         out_inv   [NDUT];
    logic         busy      [NDUT];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];
    exp_t       exp_q [$];

    // Results of the most recent tick
    logic         hs_in_seen;
    logic         hs_out_seen;
    int           tick_cyc;
    logic [127:0] act_data;
    logic         act_inv;
    logic [127:0] exp_data;
    logic         exp_inv;
    logic         exp_valid;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            sub_bytes_seq #(.BPC(BPC_TAB[gi])) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .in_data   (in_data[gi]),
                .in_inv    (in_inv[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .out_data  (out_data[gi]),
                .out_inv   (out_inv[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    task automatic build_tables();
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            s = sbox_model(8'(x));
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_block(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        for (int k = 0; k < 16; k++) begin
            b = d[127-8*k -: 8];
            r[127-8*k -: 8] = inv ? inv_tab[b] : fwd_tab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- cycle helpers ----------------
    // Sample handshakes half a cycle before the edge they complete on, keep the
    // scoreboard in step, then return just after that edge.
    task automatic tick(input int k);
        exp_t e;
        @(negedge clk);
        #1;
        tick_cyc    = cyc;
        hs_in_seen  = in_valid[k] && in_ready[k] && !rst;
        hs_out_seen = out_valid[k] && out_ready[k] && !rst;
        if (hs_in_seen) begin
            e.inv  = in_inv[k];
            e.data = ref_block(in_data[k], in_inv[k]);
            exp_q.push_back(e);
        end
        if (hs_out_seen) begin
            act_data = out_data[k];
            act_inv  = out_inv[k];
            if (exp_q.size() > 0) begin
                e         = exp_q.pop_front();
                exp_data  = e.data;
                exp_inv   = e.inv;
                exp_valid = 1'b1;
            end else begin
                exp_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input int k, input logic [127:0] d, input logic inv);
        int n = 0;
        in_data[k]  = d;
        in_inv[k]   = inv;
        in_valid[k] = 1'b1;
        do begin
            tick(k);
            n++;
        end while (!hs_in_seen && n < 64);
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, output int lat);
        lat = 0;
        while (out_valid[k] !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take_out(input int k);
        out_ready[k] = 1'b1;
        tick(k);
        out_ready[k] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 ||
                out_data[k] !== 128'h0 || out_inv[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset bpc=%0d: in_ready=%b out_valid=%b busy=%b out_data=%h out_inv=%b, required 1 0 0 0 0",
                         BPC_TAB[k], in_ready[k], out_valid[k], busy[k], out_data[k], out_inv[k]);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("test_reset: done");
    endtask

    task automatic test_zero_block();
        int lat;
        logic [127:0] want;
        want = {16{8'h63}};
        send_block(0, 128'h0, 1'b0);
        wait_out(0, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles, required 4", lat);
        end
        take_out(0);
        checks++;
        if (!hs_out_seen || act_data !== want || act_inv !== 1'b0) begin
            errors++;
            $display("FAIL zero_block: got %h inv=%b, required %h inv=0", act_data, act_inv, want);
        end
        $display("test_zero_block: latency=%0d out=%h", lat, act_data);
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] pt;
        logic [127:0] sb;
        pt = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        sb = 128'hd42711aee0bf98f1b8b45de51e415230;
        send_block(0, pt, 1'b0);
        wait_out(0, lat);
        take_out(0);
        checks++;
        if (!hs_out_seen || act_data !== sb || act_inv !== 1'b0) begin
            errors++;
            $display("FAIL fips_fwd: got %h inv=%b, required %h inv=0", act_data, act_inv, sb);
        end
        checks++;
        if (!exp_valid || act_data !== exp_data) begin
            errors++;
            $display("FAIL fips_fwd_sb: got %h, required %h", act_data, exp_data);
        end
        $display("test_fips: fwd out=%h", act_data);
        send_block(0, sb, 1'b1);
        wait_out(0, lat);
        take_out(0);
        checks++;
        if (!hs_out_seen || act_data !== pt || act_inv !== 1'b1) begin
            errors++;
            $display("FAIL fips_inv: got %h inv=%b, required %h inv=1", act_data, act_inv, pt);
        end
        $display("test_fips: inv out=%h", act_data);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] held;
        a = rand_block();
        b = rand_block();
        send_block(0, a, 1'b0);
        wait_out(0, lat);
        held = out_data[0];
        in_data[0]   = b;
        in_inv[0]    = 1'b1;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(0);
            checks++;
            if (out_data[0] !== held || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || hs_in_seen) begin
                errors++;
                bad++;
                $display("FAIL backpressure_hold: cycle %0d out_data=%h in_ready=%b out_valid=%b accepted=%b, required %h 0 1 0",
                         i, out_data[0], in_ready[0], out_valid[0], hs_in_seen, held);
            end
        end
        out_ready[0] = 1'b1;
        tick(0);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        checks++;
        if (!(hs_in_seen && hs_out_seen)) begin
            errors++;
            $display("FAIL backpressure_dual_hs: in_hs=%b out_hs=%b, required 1 1", hs_in_seen, hs_out_seen);
        end
        checks++;
        if (!exp_valid || act_data !== exp_data || act_inv !== exp_inv) begin
            errors++;
            $display("FAIL backpressure_first: got %h inv=%b, required %h inv=%b", act_data, act_inv, exp_data, exp_inv);
        end
        wait_out(0, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL backpressure_latency: got %0d, required 4", lat);
        end
        take_out(0);
        checks++;
        if (!hs_out_seen || !exp_valid || act_data !== exp_data || act_inv !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_second: got %h inv=%b, required %h inv=1", act_data, act_inv, exp_data);
        end
        $display("test_backpressure: hold errors=%0d second out=%h", bad, act_data);
    endtask

    task automatic test_single_byte();
        int lat;
        logic [127:0] want;
        want = {8'hed, {15{8'h63}}};
        send_block(0, {8'h53, 120'h0}, 1'b0);
        wait_out(0, lat);
        take_out(0);
        checks++;
        if (!hs_out_seen || act_data !== want) begin
            errors++;
            $display("FAIL single_byte_fwd: got %h, required %h", act_data, want);
        end
        $display("test_single_byte: fwd out=%h", act_data);
        want = {8'h00, {15{8'h52}}};
        send_block(0, {8'h63, 120'h0}, 1'b1);
        wait_out(0, lat);
        take_out(0);
        checks++;
        if (!hs_out_seen || act_data !== want) begin
            errors++;
            $display("FAIL single_byte_inv: got %h, required %h", act_data, want);
        end
        $display("test_single_byte: inv out=%h", act_data);
    endtask

    task automatic test_reset_mid_run();
        int stale = 0;
        send_block(0, rand_block(), 1'b1);
        tick(0);
        rst = 1'b1;
        tick(0);
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0 ||
            out_data[0] !== 128'h0 || out_inv[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: out_valid=%b in_ready=%b busy=%b out_data=%h out_inv=%b, required 0 1 0 0 0",
                     out_valid[0], in_ready[0], busy[0], out_data[0], out_inv[0]);
        end
        rst = 1'b0;
        exp_q.delete();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(0);
            if (out_valid[0] === 1'b1 || hs_out_seen) stale++;
        end
        out_ready[0] = 1'b0;
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL reset_stale: got %0d cycles with out_valid, required 0", stale);
        end
        $display("test_reset_mid_run: stale cycles=%0d", stale);
    endtask

    task automatic test_sweep(input int k);
        int lat;
        int nstep;
        logic inv;
        nstep = 16 / BPC_TAB[k];
        for (int i = 0; i < 4; i++) begin
            inv = 1'($urandom_range(0, 1));
            send_block(k, rand_block(), inv);
            wait_out(k, lat);
            checks++;
            if (lat != nstep) begin
                errors++;
                $display("FAIL sweep_latency bpc=%0d: got %0d, required %0d", BPC_TAB[k], lat, nstep);
            end
            take_out(k);
            checks++;
            if (!hs_out_seen || !exp_valid || act_data !== exp_data || act_inv !== exp_inv) begin
                errors++;
                $display("FAIL sweep_data bpc=%0d: got %h inv=%b, required %h inv=%b",
                         BPC_TAB[k], act_data, act_inv, exp_data, exp_inv);
            end
            $display("test_sweep bpc=%0d blk %0d: latency=%0d out=%h", BPC_TAB[k], i, lat, act_data);
        end
    endtask

    task automatic test_back_to_back(input int k);
        int nstep;
        int sent = 0;
        int recv = 0;
        int prev = -1;
        int guard = 0;
        nstep = 16 / BPC_TAB[k];
        exp_q.delete();
        in_data[k]   = rand_block();
        in_inv[k]    = 1'($urandom_range(0, 1));
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        while (recv < 6 && guard < 400) begin
            tick(k);
            guard++;
            if (hs_in_seen) begin
                if (prev >= 0) begin
                    checks++;
                    if (tick_cyc - prev != nstep + 1) begin
                        errors++;
                        $display("FAIL b2b_interval bpc=%0d: got %0d, required %0d", BPC_TAB[k], tick_cyc - prev, nstep + 1);
                    end
                end
                prev = tick_cyc;
                sent++;
                if (sent < 6) begin
                    in_data[k] = rand_block();
                    in_inv[k]  = 1'($urandom_range(0, 1));
                end else begin
                    in_valid[k] = 1'b0;
                end
            end
            if (hs_out_seen) begin
                recv++;
                checks++;
                if (!exp_valid || act_data !== exp_data || act_inv !== exp_inv) begin
                    errors++;
                    $display("FAIL b2b_data bpc=%0d: got %h inv=%b, required %h inv=%b",
                             BPC_TAB[k], act_data, act_inv, exp_data, exp_inv);
                end
                $display("test_back_to_back bpc=%0d blk %0d: out=%h", BPC_TAB[k], recv - 1, act_data);
            end
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        checks++;
        if (recv != 6) begin
            errors++;
            $display("FAIL b2b_count bpc=%0d: got %0d blocks, required 6", BPC_TAB[k], recv);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            in_inv[k]    = 1'b0;
            out_ready[k] = 1'b0;
        end
        build_tables();
        test_reset();
        test_zero_block();
        test_fips();
        test_backpressure();
        test_single_byte();
        test_reset_mid_run();
        for (int k = 1; k < NDUT; k++) test_sweep(k);
        for (int k = 0; k < NDUT; k++) test_back_to_back(k);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
